// File: rtl/bwm_pkg.sv
// Shared definitions for the buffered write master.
//   bwm_state_t    : transfer state (IDLE, WRITE)
//   bwm_byte_shift : log2 of bytes per word; this shift converts between
//                    byte lengths/addresses and word counts.
package bwm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } bwm_state_t;

  function automatic int bwm_byte_shift(input int bytes_per_word);
    return $clog2(bytes_per_word);
  endfunction

endpackage

// File: rtl/bwm_sync_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible on head_data
// whenever the FIFO is not empty, and pop simply advances to the next word.
// Ports:
//   clk, reset_n    : clock and synchronous active-low reset (clears occupancy)
//   push, push_data : write strobe and data; dropped while full
//   pop             : advance head; ignored while empty
//   head_data       : current head word (stale when empty)
//   count           : registered occupancy, 0..DEPTH
//   empty           : occupancy is zero
// DEPTH must equal 2**DEPTH_LOG2 so the pointers wrap naturally.
module bwm_sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  full;
  logic                  push_ok;
  logic                  pop_ok;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  // Full is judged on the registered count, so a push into a full FIFO is
  // lost even when a pop frees a slot in the same cycle.
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/buffered_write_master.sv
// Avalon-MM write master fed by a user-side FIFO. A go pulse in IDLE loads
// a start address and a byte length; words are then written from the FIFO
// head, one per accepted bus cycle, until the length is exhausted.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   coe_control_write_base       : word-aligned start address
//   coe_control_write_length     : length in bytes (rounded down to words)
//   coe_control_go               : start pulse, honoured only in IDLE
//   coe_control_fixed_location   : hold address constant (BWM_FIXED_LOCATION_EN only)
//   coe_control_done             : idle with nothing outstanding
//   coe_user_write_buffer/_data  : FIFO push strobe and data
//   coe_user_buffer_full         : FIFO full
//   master_*                     : Avalon-MM write master signals
// Optional feature macro: BWM_FIXED_LOCATION_EN.
module buffered_write_master
  import bwm_pkg::*;
#(
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int ADDRESSWIDTH    = 32,
  parameter int FIFODEPTH       = 32,
  parameter int FIFODEPTH_LOG2  = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDRESSWIDTH-1:0]    coe_control_write_base,
  input  logic [ADDRESSWIDTH-1:0]    coe_control_write_length,
  input  logic                       coe_control_go,
`ifdef BWM_FIXED_LOCATION_EN
  input  logic                       coe_control_fixed_location,
`endif
  output logic                       coe_control_done,
  input  logic                       coe_user_write_buffer,
  input  logic [DATAWIDTH-1:0]       coe_user_buffer_data,
  output logic                       coe_user_buffer_full,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_write,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  output logic [DATAWIDTH-1:0]       master_writedata,
  input  logic                       master_waitrequest
);

  localparam int                      SHIFT    = bwm_byte_shift(BYTEENABLEWIDTH);
  localparam logic [ADDRESSWIDTH-1:0] STEP     = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  localparam logic [ADDRESSWIDTH-1:0] LEN_MASK = {ADDRESSWIDTH{1'b1}} << SHIFT;
  localparam logic [FIFODEPTH_LOG2:0] FULL_COUNT = (FIFODEPTH_LOG2+1)'(FIFODEPTH);

  bwm_state_t                state;
  logic [ADDRESSWIDTH-1:0]   address;
  logic [ADDRESSWIDTH-1:0]   length;
  logic [ADDRESSWIDTH-1:0]   length_words;
  logic                      fixed_location;
  logic                      fixed_sel;
  logic                      accept;
  logic                      fifo_empty;
  logic [FIFODEPTH_LOG2:0]   fifo_count;

`ifdef BWM_FIXED_LOCATION_EN
  assign fixed_sel = coe_control_fixed_location;
`else
  assign fixed_sel = 1'b0;
`endif

  // Partial trailing words are not written.
  assign length_words = coe_control_write_length & LEN_MASK;

  assign master_write      = (state == WRITE) && (length != '0) && !fifo_empty;
  assign accept            = master_write && !master_waitrequest;
  assign master_address    = address;
  assign master_byteenable = '1;
  assign coe_control_done  = (state == IDLE) && (length == '0);
  assign coe_user_buffer_full = (fifo_count == FULL_COUNT);

  bwm_sync_fifo #(
    .WIDTH      (DATAWIDTH),
    .DEPTH      (FIFODEPTH),
    .DEPTH_LOG2 (FIFODEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (coe_user_write_buffer),
    .push_data (coe_user_buffer_data),
    .pop       (accept),
    .head_data (master_writedata),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Address, length and fixed flag only move on go or an accepted write,
  // which keeps the bus request stable across waitrequest.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      address        <= '0;
      length         <= '0;
      fixed_location <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (coe_control_go) begin
            address        <= coe_control_write_base;
            length         <= length_words;
            fixed_location <= fixed_sel;
            if (length_words != '0) begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (length == '0) begin
            state <= IDLE;
          end else if (accept) begin
            length <= length - STEP;
            if (!fixed_location) begin
              address <= address + STEP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffered_write_master.sv
module tb_buffered_write_master;

  localparam int DW  = 32;
  localparam int BEW = 4;
  localparam int AW  = 32;
  localparam int FD  = 32;
  localparam int FDL = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] write_base;
  logic [AW-1:0] write_length;
  logic          go;
`ifdef BWM_FIXED_LOCATION_EN
  logic          fixed_location;
`endif
  logic          done;
  logic          write_buffer;
  logic [DW-1:0] buffer_data;
  logic          buffer_full;
  logic [AW-1:0] master_address;
  logic          master_write;
  logic [BEW-1:0] master_byteenable;
  logic [DW-1:0] master_writedata;
  logic          master_waitrequest;

  int checks = 0;
  int errors = 0;

  // Words the bench expects the FIFO to hold, in order.
  logic [DW-1:0] exp_data[$];

  typedef struct {
    int            pre;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    int            exp_writes;
    logic [AW-1:0] exp_last;
    int            exp_done;
  } vec_t;

  vec_t vecs[5];

  buffered_write_master #(
    .DATAWIDTH       (DW),
    .BYTEENABLEWIDTH (BEW),
    .ADDRESSWIDTH    (AW),
    .FIFODEPTH       (FD),
    .FIFODEPTH_LOG2  (FDL)
  ) dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .coe_control_write_base     (write_base),
    .coe_control_write_length   (write_length),
    .coe_control_go             (go),
`ifdef BWM_FIXED_LOCATION_EN
    .coe_control_fixed_location (fixed_location),
`endif
    .coe_control_done           (done),
    .coe_user_write_buffer      (write_buffer),
    .coe_user_buffer_data       (buffer_data),
    .coe_user_buffer_full       (buffer_full),
    .master_address             (master_address),
    .master_write               (master_write),
    .master_byteenable          (master_byteenable),
    .master_writedata           (master_writedata),
    .master_waitrequest         (master_waitrequest)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    go = 1'b0;
    write_buffer = 1'b0;
    master_waitrequest = 1'b0;
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    exp_data.delete();
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] start);
    for (int i = 0; i < n; i++) begin
      write_buffer = 1'b1;
      buffer_data  = start + DW'(i);
      exp_data.push_back(start + DW'(i));
      cycle();
    end
    write_buffer = 1'b0;
  endtask

  // Issues one command and watches the bus for maxcyc cycles. The write
  // numbered wait_idx (0-based) is stalled for wait_len cycles.
  task automatic run_cmd(input logic [AW-1:0] base, input logic [AW-1:0] len,
                         input bit fixed, input int wait_idx, input int wait_len,
                         input int maxcyc, output int nw, output int done_cyc,
                         output logic [AW-1:0] last_addr);
    int stall;
    logic [AW-1:0] exp_a;
    write_base   = base;
    write_length = len;
`ifdef BWM_FIXED_LOCATION_EN
    fixed_location = fixed;
`endif
    go = 1'b1;
    cycle();
    go = 1'b0;
    nw = 0;
    done_cyc = 0;
    stall = 0;
    last_addr = '0;
    for (int k = 1; k <= maxcyc; k++) begin
      #1;
      if (done && done_cyc == 0) done_cyc = k;
      master_waitrequest = 1'b0;
      if (master_write) begin
        exp_a = fixed ? base : base + AW'(nw * BEW);
        if (exp_data.size() == 0) begin
          check("spurious_write", 64'(master_write), 64'd0);
        end else if (nw == wait_idx && stall < wait_len) begin
          master_waitrequest = 1'b1;
          stall++;
          check("stall_addr", 64'(master_address), 64'(exp_a));
          check("stall_data", 64'(master_writedata), 64'(exp_data[0]));
        end else begin
          check("write_addr", 64'(master_address), 64'(exp_a));
          check("write_data", 64'(master_writedata), 64'(exp_data[0]));
          check("byteenable", 64'(master_byteenable), 64'hF);
          last_addr = master_address;
          void'(exp_data.pop_front());
          nw++;
        end
      end
      cycle();
    end
    master_waitrequest = 1'b0;
  endtask

  // Random stimulus against a transaction-level model: a queue of buffered
  // words, a remaining byte count and a busy flag.
  task automatic random_test(input int ncyc);
    logic [DW-1:0] mq[$];
    logic [AW-1:0] m_addr = '0;
    logic [AW-1:0] m_rem  = '0;
    bit m_busy = 1'b0;
    bit m_fixed = 1'b0;
    bit exp_write, acc, push_ok, f;
    for (int c = 0; c < ncyc; c++) begin
      write_buffer       = ($urandom_range(0, 3) != 0);
      buffer_data        = $urandom;
      go                 = ($urandom_range(0, 7) == 0);
      write_base         = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
      write_length       = $urandom_range(0, 48);
      master_waitrequest = ($urandom_range(0, 3) == 0);
      f                  = ($urandom_range(0, 3) == 0);
`ifdef BWM_FIXED_LOCATION_EN
      fixed_location = f;
`else
      f = 1'b0;
`endif
      #1;
      exp_write = m_busy && (m_rem != 0) && (mq.size() != 0);
      check("rnd_write", 64'(master_write), 64'(exp_write));
      if (exp_write && mq.size() != 0) begin
        check("rnd_addr", 64'(master_address), 64'(m_addr));
        check("rnd_data", 64'(master_writedata), 64'(mq[0]));
      end
      check("rnd_done", 64'(done), 64'(!m_busy && m_rem == 0));
      check("rnd_full", 64'(buffer_full), 64'(mq.size() == FD));
      acc     = exp_write && !master_waitrequest;
      push_ok = write_buffer && (mq.size() < FD);
      if (acc) void'(mq.pop_front());
      if (push_ok) mq.push_back(buffer_data);
      if (!m_busy) begin
        if (go) begin
          m_addr  = write_base;
          m_rem   = write_length & ~32'(BEW - 1);
          m_fixed = f;
          m_busy  = (m_rem != 0);
        end
      end else if (m_rem == 0) begin
        m_busy = 1'b0;
      end else if (acc) begin
        m_rem = m_rem - BEW;
        if (!m_fixed) m_addr = m_addr + BEW;
      end
      cycle();
    end
    go = 1'b0;
    write_buffer = 1'b0;
    master_waitrequest = 1'b0;
  endtask

  initial begin
    int nw, dc;
    logic [AW-1:0] la;

    vecs[0] = '{pre: 4, base: 32'h0000_1000, len: 32'd16, exp_writes: 4, exp_last: 32'h0000_100C, exp_done: 6};
    vecs[1] = '{pre: 4, base: 32'h0000_1000, len: 32'd0,  exp_writes: 0, exp_last: 32'h0,         exp_done: 1};
    vecs[2] = '{pre: 4, base: 32'h0000_3000, len: 32'd18, exp_writes: 4, exp_last: 32'h0000_300C, exp_done: 6};
    vecs[3] = '{pre: 4, base: 32'hFFFF_FFF8, len: 32'd16, exp_writes: 4, exp_last: 32'h0000_0004, exp_done: 6};
    vecs[4] = '{pre: 6, base: 32'h0000_0040, len: 32'd8,  exp_writes: 2, exp_last: 32'h0000_0044, exp_done: 4};

    write_base = '0;
    write_length = '0;
    buffer_data = '0;
`ifdef BWM_FIXED_LOCATION_EN
    fixed_location = 1'b0;
`endif
    cycle();
    do_reset();
    #1;
    check("reset_write", 64'(master_write), 64'd0);
    check("reset_done",  64'(done), 64'd1);
    check("reset_full",  64'(buffer_full), 64'd0);
    check("reset_addr",  64'(master_address), 64'd0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      push_words(vecs[v].pre, 32'hA0);
      run_cmd(vecs[v].base, vecs[v].len, 1'b0, -1, 0, 12, nw, dc, la);
      check("vec_writes", 64'(nw), 64'(vecs[v].exp_writes));
      check("vec_done_cycle", 64'(dc), 64'(vecs[v].exp_done));
      if (vecs[v].exp_writes > 0) check("vec_last_addr", 64'(la), 64'(vecs[v].exp_last));
      #1;
      check("vec_done_end", 64'(done), 64'd1);
    end

    // Waitrequest held for 3 cycles on the second write.
    do_reset();
    push_words(4, 32'hA0);
    run_cmd(32'h1000, 32'd16, 1'b0, 1, 3, 16, nw, dc, la);
    check("wait_writes", 64'(nw), 64'd4);
    check("wait_done_cycle", 64'(dc), 64'd9);
    check("wait_last_addr", 64'(la), 64'h100C);

    // Fill beyond capacity without a command.
    do_reset();
    for (int i = 0; i < 33; i++) begin
      write_buffer = 1'b1;
      buffer_data  = 32'hB00 + 32'(i);
      #1;
      check("fill_full", 64'(buffer_full), 64'(i >= FD));
      if (i < FD) exp_data.push_back(32'hB00 + 32'(i));
      cycle();
    end
    write_buffer = 1'b0;
    #1;
    check("fill_full_after", 64'(buffer_full), 64'd1);
    run_cmd(32'h0, 32'd128, 1'b0, -1, 0, 40, nw, dc, la);
    check("fill_writes", 64'(nw), 64'd32);
    check("fill_done_cycle", 64'(dc), 64'd34);
    check("fill_last_addr", 64'(la), 64'h7C);
    #1;
    check("fill_full_drained", 64'(buffer_full), 64'd0);

    // Reset in the middle of an 8-word transfer.
    do_reset();
    push_words(8, 32'hD0);
    write_base = 32'h5000;
    write_length = 32'd32;
    go = 1'b1;
    cycle();
    go = 1'b0;
    #1;
    check("mid_w0_addr", 64'(master_address), 64'h5000);
    cycle();
    #1;
    check("mid_w1_addr", 64'(master_address), 64'h5004);
    cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    exp_data.delete();
    #1;
    check("mid_reset_write", 64'(master_write), 64'd0);
    check("mid_reset_done",  64'(done), 64'd1);
    check("mid_reset_full",  64'(buffer_full), 64'd0);
    check("mid_reset_addr",  64'(master_address), 64'd0);
    write_base = 32'h6000;
    write_length = 32'd4;
    go = 1'b1;
    cycle();
    go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mid_fifo_empty", 64'(master_write), 64'd0);
      cycle();
    end
    write_buffer = 1'b1;
    buffer_data = 32'hC0;
    cycle();
    write_buffer = 1'b0;
    #1;
    check("mid_new_write", 64'(master_write), 64'd1);
    check("mid_new_addr",  64'(master_address), 64'h6000);
    check("mid_new_data",  64'(master_writedata), 64'hC0);
    cycle();

`ifdef BWM_FIXED_LOCATION_EN
    do_reset();
    push_words(3, 32'hE0);
    run_cmd(32'h2000, 32'd12, 1'b1, -1, 0, 10, nw, dc, la);
    check("fixed_writes", 64'(nw), 64'd3);
    check("fixed_last_addr", 64'(la), 64'h2000);
    check("fixed_done_cycle", 64'(dc), 64'd5);
    fixed_location = 1'b0;
`endif

    do_reset();
    random_test(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffered_write_master.md
BUFFERED_WRITE_MASTER -- requirements
Module: buffered_write_master

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, Avalon data width in bits.
REQ-002 SHALL have parameter BYTEENABLEWIDTH, default 4, bytes per word (DATAWIDTH/8).
REQ-003 SHALL have parameter ADDRESSWIDTH, default 32, byte address and length width.
REQ-004 SHALL have parameter FIFODEPTH, default 32, user-to-master FIFO words.
REQ-005 SHALL have parameter FIFODEPTH_LOG2, default 5, log2(FIFODEPTH).
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge; reset_n  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports: coe_control_write_base  in  ADDRESSWIDTH  word-aligned start address; coe_control_write_length  in  ADDRESSWIDTH  length in bytes; coe_control_go  in  1  start pulse; coe_control_done  out  1  idle, all writes accepted.
REQ-008 SHALL have ports: coe_user_write_buffer  in  1  push strobe; coe_user_buffer_data  in  DATAWIDTH  push data; coe_user_buffer_full  out  1  FIFO full.
REQ-009 SHALL have ports: master_address  out  ADDRESSWIDTH; master_write  out  1; master_byteenable  out  BYTEENABLEWIDTH; master_writedata  out  DATAWIDTH; master_waitrequest  in  1.

Function
REQ-010 SHALL implement states IDLE and WRITE; reset -> IDLE.
REQ-011 SHALL, on go in IDLE, load address from write_base, length from write_length with low log2(BYTEENABLEWIDTH) bits cleared, and enter WRITE next cycle; SHALL ignore go in WRITE.
REQ-012 SHALL return from WRITE to IDLE the cycle after length reaches 0; SHALL stay in IDLE when go is given with a zero length.
REQ-013 SHALL assert master_write = WRITE & (length != 0) & FIFO not empty, combinationally; SHALL drive master_writedata from the show-ahead FIFO head.
REQ-014 SHALL hold master_address, master_writedata and master_write stable while master_waitrequest=1.
REQ-015 SHALL, on each accepted write (master_write & !master_waitrequest), pop the FIFO, subtract BYTEENABLEWIDTH from length and add BYTEENABLEWIDTH to address; maximum throughput one word per cycle.
REQ-016 SHALL drive master_byteenable all ones.
REQ-017 SHALL push on coe_user_write_buffer when not full; SHALL silently drop a push while full, even if a pop occurs in the same cycle.
REQ-018 SHALL perform simultaneous push and pop when not full with occupancy unchanged; SHALL ignore a pop while empty.
REQ-019 SHALL assert coe_user_buffer_full when occupancy = FIFODEPTH (registered count).
REQ-020 SHALL drive coe_control_done = IDLE & (length == 0).
REQ-021 SHALL not flush the FIFO on go; leftover words are written by the next command.
REQ-022 SHALL perform address arithmetic modulo 2^ADDRESSWIDTH (wrap-around, no error).

Reset
REQ-023 SHALL, with reset_n=0 at a clk edge, clear state to IDLE, address, length and FIFO occupancy to 0, including mid-transfer; outputs after reset: master_write=0, coe_control_done=1, coe_user_buffer_full=0, master_address=0.

Configuration
REQ-024 SHALL support macro BWM_FIXED_LOCATION_EN: when defined, add input coe_control_fixed_location (1 bit), sampled on an accepted go; when it is 1, address is held constant for the whole transfer; when the macro is undefined, the port is absent and the address always increments.

Structure
REQ-025 SHALL place the state enum (IDLE, WRITE) and the byte-per-word shift constant in shared package bwm_pkg.
REQ-026 SHALL instantiate one sub-module, bwm_sync_fifo (show-ahead, synchronous, parameterised width/depth, count output).

Verification
REQ-027 SHALL cover: preload 4 words 0xA0..0xA3, go base=0x1000 len=16, no waitrequest -> writes at 0x1000/4/8/C on 4 consecutive cycles, done high on the 6th cycle after go.
REQ-028 SHALL cover: waitrequest high for 3 cycles on the 2nd write -> address 0x1004 and data held, 4 total writes, no loss.
REQ-029 SHALL cover: push 33 words with no go (FIFODEPTH=32) -> full high after 32 pushes, 33rd dropped, later transfer of len=128 emits 32 words.
REQ-030 SHALL cover: go len=0 -> no master_write, done stays 1; go len=18 -> exactly 4 writes.
REQ-031 SHALL cover: reset_n low mid-transfer after 2 of 8 writes -> next cycle master_write=0, done=1, full=0, FIFO empty.
REQ-032 SHALL cover, with BWM_FIXED_LOCATION_EN and fixed_location=1, base=0x2000 len=12 -> 3 writes all to 0x2000.
